// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Clocked byte/half/word data memory with valid/ready request handshake,
// configurable response latency and misalignment error reporting.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_pend_q, err_pend_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic             accept_c;
  logic             mis_c;
  logic             wr_en_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       lane_c;
  logic [31:0]      word_rd_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_val_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_rep_c;

  // Request decode: alignment, lane selection and load extension.
  always_comb begin
    accept_c  = bus.req_valid && ready_q;
    idx_c     = bus.req_addr[ADDR_W-1:2];
    lane_c    = bus.req_addr[1:0];
    word_rd_c = mem[idx_c];
    byte_c    = word_rd_c[{lane_c, 3'b000} +: 8];
    half_c    = word_rd_c[{lane_c[1], 4'b0000} +: 16];

    mis_c       = 1'b0;
    load_val_c  = word_rd_c;
    be_c        = 4'b1111;
    wdata_rep_c = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        load_val_c  = bus.req_unsigned ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
        be_c        = 4'(4'b0001 << lane_c);
        wdata_rep_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        mis_c       = lane_c[0];
        load_val_c  = bus.req_unsigned ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
        be_c        = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   mis_c = (lane_c != 2'b00);
      default: mis_c = 1'b1;
    endcase
    wr_en_c = accept_c && bus.req_we && !mis_c;
  end

  // Next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_pend_d = err_pend_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          data_d     = (bus.req_we || mis_c) ? 32'h0 : load_val_c;
          err_pend_d = mis_c;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
    rdata_d = valid_d ? data_d : 32'h0;
    err_d   = valid_d && err_pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_q     <= 32'h0;
      err_pend_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_pend_q <= err_pend_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one LATENCY=1 and one LATENCY=4 instance.
module tb_data_mem_ctrl;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] q1[$];
  logic [32:0] q4[$];

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(AW)) if1 ();
  data_mem_ctrl_if #(.ADDR_W(AW)) if4 ();

  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // Response monitors: pop the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (if1.resp_valid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL lat1_unexpected_resp got rdata=%h err=%b", if1.resp_rdata, if1.resp_err);
        end else begin
          logic [32:0] e;
          e = q1.pop_front();
          if ({if1.resp_err, if1.resp_rdata} !== e) begin
            errors++; $display("FAIL lat1_resp got err=%b rdata=%h want err=%b rdata=%h",
                               if1.resp_err, if1.resp_rdata, e[32], e[31:0]);
          end
        end
        checks++;
        if (if1.req_ready !== 1'b0) begin
          errors++; $display("FAIL lat1_ready_in_resp got %b want 0", if1.req_ready);
        end
      end else begin
        checks++;
        if (if1.resp_rdata !== 32'h0 || if1.resp_err !== 1'b0) begin
          errors++; $display("FAIL lat1_idle_out got rdata=%h err=%b want 0/0", if1.resp_rdata, if1.resp_err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if4.resp_valid) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("FAIL lat4_unexpected_resp got rdata=%h err=%b", if4.resp_rdata, if4.resp_err);
        end else begin
          logic [32:0] e;
          e = q4.pop_front();
          if ({if4.resp_err, if4.resp_rdata} !== e) begin
            errors++; $display("FAIL lat4_resp got err=%b rdata=%h want err=%b rdata=%h",
                               if4.resp_err, if4.resp_rdata, e[32], e[31:0]);
          end
        end
        checks++;
        if (if4.req_ready !== 1'b0) begin
          errors++; $display("FAIL lat4_ready_in_resp got %b want 0", if4.req_ready);
        end
      end else begin
        checks++;
        if (if4.resp_rdata !== 32'h0 || if4.resp_err !== 1'b0) begin
          errors++; $display("FAIL lat4_idle_out got rdata=%h err=%b want 0/0", if4.resp_rdata, if4.resp_err);
        end
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [AW-1:0] a, input logic [31:0] wd);
    if (!sel) begin
      if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
      if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
    end else begin
      if4.req_valid = v; if4.req_we = we; if4.req_size = sz;
      if4.req_unsigned = uns; if4.req_addr = a; if4.req_wdata = wd;
    end
  endtask

  // One request: wait for ready, push expectation at accept, check latency.
  task automatic do_req(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_data);
    int  n;
    int  lat;
    bit  rdy;
    lat = sel ? 4 : 1;
    @(negedge clk);
    drive(sel, 1'b1, we, sz, uns, a, wd);
    n = 0;
    rdy = sel ? if4.req_ready : if1.req_ready;
    while (!rdy && n < 50) begin
      @(negedge clk); n++;
      rdy = sel ? if4.req_ready : if1.req_ready;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout addr=%h got ready=0 want 1", a);
      drive(sel, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
      return;
    end
    @(posedge clk);
    if (sel) q4.push_back({exp_err, exp_data});
    else     q1.push_back({exp_err, exp_data});
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) drive(sel, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
      #1;
    end while ((sel ? q4.size() : q1.size()) != 0 && n < 50);
    checks++;
    if (n != lat) begin
      errors++; $display("FAIL resp_latency addr=%h got %0d want %0d", a, n, lat);
      q1.delete(); q4.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({if1.req_ready, if1.resp_valid, if1.resp_rdata, if1.resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_lat1 got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                         if1.req_ready, if1.resp_valid, if1.resp_rdata, if1.resp_err);
    end
    checks++;
    if ({if4.req_ready, if4.resp_valid, if4.resp_rdata, if4.resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_lat4 got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                         if4.req_ready, if4.resp_valid, if4.resp_rdata, if4.resp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    do_req(0, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 0, 32'h0);
    do_req(0, 0, 2'b10, 0, 9'h010, 32'h0, 0, 32'hDEADBEEF);
  endtask

  task automatic test_byte();
    do_req(0, 1, 2'b00, 0, 9'h011, 32'hFFFFFF5A, 0, 32'h0);
    do_req(0, 0, 2'b10, 0, 9'h010, 32'h0, 0, 32'hDEAD5AEF);
    do_req(0, 0, 2'b00, 0, 9'h013, 32'h0, 0, 32'hFFFFFFDE);
    do_req(0, 0, 2'b00, 1, 9'h013, 32'h0, 0, 32'h000000DE);
    do_req(0, 0, 2'b00, 0, 9'h011, 32'h0, 0, 32'h0000005A);
  endtask

  task automatic test_half();
    do_req(0, 1, 2'b10, 0, 9'h020, 32'hCAFE1234, 0, 32'h0);
    do_req(0, 1, 2'b01, 0, 9'h022, 32'hFFFF8001, 0, 32'h0);
    do_req(0, 0, 2'b01, 0, 9'h022, 32'h0, 0, 32'hFFFF8001);
    do_req(0, 0, 2'b01, 1, 9'h022, 32'h0, 0, 32'h00008001);
    do_req(0, 0, 2'b10, 0, 9'h020, 32'h0, 0, 32'h80011234);
    do_req(0, 0, 2'b01, 0, 9'h020, 32'h0, 0, 32'h00001234);
  endtask

  task automatic test_misalign();
    do_req(0, 1, 2'b01, 0, 9'h023, 32'h0000FFFF, 1, 32'h0);
    do_req(0, 0, 2'b10, 0, 9'h022, 32'h0, 1, 32'h0);
    do_req(0, 0, 2'b11, 0, 9'h000, 32'h0, 1, 32'h0);
    do_req(0, 1, 2'b10, 0, 9'h021, 32'h55555555, 1, 32'h0);
    do_req(0, 0, 2'b10, 0, 9'h020, 32'h0, 0, 32'h80011234);
  endtask

  // Hold a word load for 10 cycles at LATENCY=4: accepts at edges 0 and 5.
  task automatic test_back_to_back();
    do_req(1, 1, 2'b10, 0, 9'h010, 32'h0BADF00D, 0, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    checks++;
    if (if4.req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_start got %b want 1", if4.req_ready);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (k % 5 == 0) q4.push_back({1'b0, 32'h0BADF00D});
      @(negedge clk);
      checks++;
      if (if4.req_ready !== (k % 5 == 4) || if4.resp_valid !== (k % 5 == 3)) begin
        errors++; $display("FAIL b2b_cycle%0d got rdy=%b v=%b want rdy=%b v=%b", k + 1,
                           if4.req_ready, if4.resp_valid, (k % 5 == 4), (k % 5 == 3));
      end
    end
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (q4.size() != 0) begin
      errors++; $display("FAIL b2b_pending got %0d want 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 9'h040, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
    checks++;
    if (if4.req_ready !== 1'b0) begin
      errors++; $display("FAIL wait_ready got %b want 0", if4.req_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({if4.req_ready, if4.resp_valid, if4.resp_rdata, if4.resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL async_reset got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                         if4.req_ready, if4.resp_valid, if4.resp_rdata, if4.resp_err);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_req(1, 0, 2'b10, 0, 9'h040, 32'h0, 0, 32'h12345678);
    do_req(0, 0, 2'b10, 0, 9'h020, 32'h0, 0, 32'h80011234);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
